// File: rtl/tlp_tx_pkg.sv
// Shared types for the TLP transmit arbiter.
//   arb_state_t : arbiter state. IDLE selects the next owner, XFER forwards
//                 one packet from the owner.
package tlp_tx_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE,
    ARB_XFER
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational one-hot request picker.
//   req     : per-channel request vector
//   ptr     : round-robin start index, used only when rr_mode is high
//   rr_mode : 1 = first requester at or after ptr, wrapping upward
//             0 = lowest-index requester
//   winner  : one-hot winner; all zero when nothing requests
module rr_pick
  import tlp_tx_pkg::*;
#(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned PTR_W  = 1
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [PTR_W-1:0]  ptr,
  input  logic              rr_mode,
  output logic [NUM_CH-1:0] winner
);

  logic found;

  // The first pass covers channels ptr..NUM_CH-1. The second pass covers the
  // wrap-around, and it is also the whole search in strict-priority mode.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    if (rr_mode) begin
      for (int i = 0; i < int'(NUM_CH); i++) begin
        if (!found && req[i] && (i >= int'(ptr))) begin
          winner[i] = 1'b1;
          found     = 1'b1;
        end
      end
    end
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (!found && req[i]) begin
        winner[i] = 1'b1;
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tlp_tx_arbiter.sv
// Packet-atomic N-channel arbiter. It merges TLP AXI-Stream sources onto
// the single PCIe core TX stream.
//   pcie_clk, sys_rst_n : clock and asynchronous active-low reset
//   s_*                 : packed per-channel source streams (ch i at slice i)
//   m_*                 : merged stream to the PCIe core
//   grant               : one-hot current owner; zero while idle
//   busy                : high while a packet is being forwarded
//   pkt_cnt             : packed per-channel completed-packet counters (wrap)
// One idle cycle is spent selecting each packet's owner. After that the data
// path is a pure mux with no added latency.
module tlp_tx_arbiter
  import tlp_tx_pkg::*;
#(
  parameter int unsigned C_DATA_WIDTH = 64,
  parameter int unsigned KEEP_WIDTH   = C_DATA_WIDTH / 8,
  parameter int unsigned TUSER_WIDTH  = 4,
  parameter int unsigned NUM_CH       = 2,
  parameter int unsigned RR_MODE      = 1,
  parameter int unsigned CNT_WIDTH    = 32
) (
  input  logic                          pcie_clk,
  input  logic                          sys_rst_n,
  input  logic [NUM_CH-1:0]             s_tvalid,
  output logic [NUM_CH-1:0]             s_tready,
  input  logic [NUM_CH-1:0]             s_tlast,
  input  logic [NUM_CH*C_DATA_WIDTH-1:0] s_tdata,
  input  logic [NUM_CH*KEEP_WIDTH-1:0]  s_tkeep,
  input  logic [NUM_CH*TUSER_WIDTH-1:0] s_tuser,
  output logic                          m_tvalid,
  input  logic                          m_tready,
  output logic                          m_tlast,
  output logic [C_DATA_WIDTH-1:0]       m_tdata,
  output logic [KEEP_WIDTH-1:0]         m_tkeep,
  output logic [TUSER_WIDTH-1:0]        m_tuser,
  output logic [NUM_CH-1:0]             grant,
  output logic                          busy,
  output logic [NUM_CH*CNT_WIDTH-1:0]   pkt_cnt
);

  localparam int unsigned PTR_W = $clog2(NUM_CH);

  arb_state_t           state_q, state_d;
  logic [NUM_CH-1:0]    grant_q, grant_d;
  logic [NUM_CH-1:0]    winner;
  logic [PTR_W-1:0]     ptr_q, ptr_d;
  logic [PTR_W-1:0]     gidx;
  logic [CNT_WIDTH-1:0] cnt_q [NUM_CH];
  logic                 xfer;
  logic                 pkt_done;

  rr_pick #(
    .NUM_CH (NUM_CH),
    .PTR_W  (PTR_W)
  ) u_pick (
    .req     (s_tvalid),
    .ptr     (ptr_q),
    .rr_mode (RR_MODE != 0),
    .winner  (winner)
  );

  assign xfer     = (state_q == ARB_XFER);
  assign busy     = xfer;
  assign grant    = grant_q;
  assign s_tready = xfer ? (grant_q & {NUM_CH{m_tready}}) : '0;
  assign pkt_done = m_tvalid & m_tready & m_tlast;

  // Outputs are forced to zero outside XFER so that no idle-source X reaches
  // the core. The reset also reaches them at once through state_q and grant_q.
  always_comb begin
    m_tvalid = 1'b0;
    m_tlast  = 1'b0;
    m_tdata  = '0;
    m_tkeep  = '0;
    m_tuser  = '0;
    gidx     = '0;
    if (xfer) begin
      for (int i = 0; i < int'(NUM_CH); i++) begin
        if (grant_q[i]) begin
          m_tvalid = s_tvalid[i];
          m_tlast  = s_tlast[i];
          m_tdata  = s_tdata[i*C_DATA_WIDTH +: C_DATA_WIDTH];
          m_tkeep  = s_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH];
          m_tuser  = s_tuser[i*TUSER_WIDTH +: TUSER_WIDTH];
          gidx     = PTR_W'(i);
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    case (state_q)
      ARB_IDLE: begin
        if (|s_tvalid) begin
          grant_d = winner;
          state_d = ARB_XFER;
        end
      end
      ARB_XFER: begin
        // Stay locked until the owner's tlast, even across source valid gaps.
        if (pkt_done) begin
          grant_d = '0;
          state_d = ARB_IDLE;
          if (RR_MODE != 0) begin
            ptr_d = (gidx == PTR_W'(NUM_CH - 1)) ? '0 : gidx + PTR_W'(1);
          end
        end
      end
      default: begin
        grant_d = '0;
        state_d = ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge pcie_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
    end
  end

  always_ff @(posedge pcie_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int i = 0; i < int'(NUM_CH); i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < int'(NUM_CH); i++) begin
        if (pkt_done && grant_q[i]) cnt_q[i] <= cnt_q[i] + CNT_WIDTH'(1);
      end
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_cnt
    assign pkt_cnt[i*CNT_WIDTH +: CNT_WIDTH] = cnt_q[i];
  end

endmodule

// File: tb/tb_tlp_tx_arbiter.sv
// Directed bench for tlp_tx_arbiter.
// Instance A: 4 channels, round-robin mode, 4-bit counters, driven by
// per-channel packet sources.
// Instance B: 2 channels, strict-priority mode, single-beat packets.
module tb_tlp_tx_arbiter;

  localparam int unsigned DW  = 64;
  localparam int unsigned KW  = 8;
  localparam int unsigned UW  = 4;
  localparam int unsigned NA  = 4;
  localparam int unsigned CWA = 4;
  localparam int unsigned NB  = 2;
  localparam int unsigned CWB = 32;

  logic pcie_clk  = 1'b0;
  logic sys_rst_n = 1'b0;
  always #5 pcie_clk = ~pcie_clk;

  // Instance A signals
  logic [NA-1:0]     a_s_tvalid, a_s_tready, a_s_tlast;
  logic [NA*DW-1:0]  a_s_tdata;
  logic [NA*KW-1:0]  a_s_tkeep;
  logic [NA*UW-1:0]  a_s_tuser;
  logic              a_m_tvalid, a_m_tready, a_m_tlast;
  logic [DW-1:0]     a_m_tdata;
  logic [KW-1:0]     a_m_tkeep;
  logic [UW-1:0]     a_m_tuser;
  logic [NA-1:0]     a_grant;
  logic              a_busy;
  logic [NA*CWA-1:0] a_pkt_cnt;

  // Instance B signals
  logic [NB-1:0]     b_s_tvalid, b_s_tready;
  logic [NB-1:0]     b_s_tlast;
  logic [NB*DW-1:0]  b_s_tdata;
  logic [NB*KW-1:0]  b_s_tkeep;
  logic [NB*UW-1:0]  b_s_tuser;
  logic              b_m_tvalid, b_m_tready, b_m_tlast;
  logic [DW-1:0]     b_m_tdata;
  logic [KW-1:0]     b_m_tkeep;
  logic [UW-1:0]     b_m_tuser;
  logic [NB-1:0]     b_grant;
  logic              b_busy;
  logic [NB*CWB-1:0] b_pkt_cnt;

  tlp_tx_arbiter #(
    .C_DATA_WIDTH (DW),
    .KEEP_WIDTH   (KW),
    .TUSER_WIDTH  (UW),
    .NUM_CH       (NA),
    .RR_MODE      (1),
    .CNT_WIDTH    (CWA)
  ) dut_a (
    .pcie_clk  (pcie_clk),
    .sys_rst_n (sys_rst_n),
    .s_tvalid  (a_s_tvalid),
    .s_tready  (a_s_tready),
    .s_tlast   (a_s_tlast),
    .s_tdata   (a_s_tdata),
    .s_tkeep   (a_s_tkeep),
    .s_tuser   (a_s_tuser),
    .m_tvalid  (a_m_tvalid),
    .m_tready  (a_m_tready),
    .m_tlast   (a_m_tlast),
    .m_tdata   (a_m_tdata),
    .m_tkeep   (a_m_tkeep),
    .m_tuser   (a_m_tuser),
    .grant     (a_grant),
    .busy      (a_busy),
    .pkt_cnt   (a_pkt_cnt)
  );

  tlp_tx_arbiter #(
    .C_DATA_WIDTH (DW),
    .KEEP_WIDTH   (KW),
    .TUSER_WIDTH  (UW),
    .NUM_CH       (NB),
    .RR_MODE      (0),
    .CNT_WIDTH    (CWB)
  ) dut_b (
    .pcie_clk  (pcie_clk),
    .sys_rst_n (sys_rst_n),
    .s_tvalid  (b_s_tvalid),
    .s_tready  (b_s_tready),
    .s_tlast   (b_s_tlast),
    .s_tdata   (b_s_tdata),
    .s_tkeep   (b_s_tkeep),
    .s_tuser   (b_s_tuser),
    .m_tvalid  (b_m_tvalid),
    .m_tready  (b_m_tready),
    .m_tlast   (b_m_tlast),
    .m_tdata   (b_m_tdata),
    .m_tkeep   (b_m_tkeep),
    .m_tuser   (b_m_tuser),
    .grant     (b_grant),
    .busy      (b_busy),
    .pkt_cnt   (b_pkt_cnt)
  );

  assign b_s_tlast = 2'b11;
  assign b_s_tdata = {64'hB1, 64'hB0};
  assign b_s_tkeep = '1;
  assign b_s_tuser = '0;

  // Packet sources for instance A. Beat data is {channel, beat index}. The
  // last beat carries keep 0x0F.
  logic [NA-1:0] en, hold;
  int            len [NA];
  logic [3:0]    beat [NA];

  always_comb begin
    a_s_tvalid = '0;
    a_s_tlast  = '0;
    a_s_tdata  = '0;
    a_s_tkeep  = '0;
    a_s_tuser  = '0;
    for (int i = 0; i < int'(NA); i++) begin
      a_s_tvalid[i]          = en[i] & ~hold[i];
      a_s_tlast[i]           = (int'(beat[i]) == len[i] - 1);
      a_s_tdata[i*DW +: DW]  = {56'h0, 4'(i), beat[i]};
      a_s_tkeep[i*KW +: KW]  = a_s_tlast[i] ? 8'h0F : 8'hFF;
      a_s_tuser[i*UW +: UW]  = 4'(i);
    end
  end

  always @(posedge pcie_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int i = 0; i < int'(NA); i++) beat[i] <= '0;
    end else begin
      for (int i = 0; i < int'(NA); i++) begin
        if (a_s_tvalid[i] && a_s_tready[i]) beat[i] <= a_s_tlast[i] ? 4'd0 : beat[i] + 4'd1;
      end
    end
  end

  // Output beat log {tlast, data[7:0]}. Sampled on the falling edge, half a
  // cycle before the transfer edge.
  logic [8:0] log_q [$];
  always @(negedge pcie_clk) begin
    if (sys_rst_n && a_m_tvalid && a_m_tready) log_q.push_back({a_m_tlast, a_m_tdata[7:0]});
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge pcie_clk);
    #1;
  endtask

  task automatic do_reset();
    sys_rst_n = 1'b0;
    repeat (2) step();
    @(negedge pcie_clk);
    sys_rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rp, hp;
    logic [8:0] exp6 [6];
    int         n;

    en         = '0;
    hold       = '0;
    for (int i = 0; i < int'(NA); i++) len[i] = 3;
    a_m_tready = 1'b1;
    b_s_tvalid = '0;
    b_m_tready = 1'b1;

    // Reset held with requests pending: everything must stay quiet.
    en = 4'b0011;
    repeat (10) step();
    check("rst_grant", a_grant, 0);
    check("rst_busy", a_busy, 0);
    check("rst_mvalid", a_m_tvalid, 0);
    check("rst_sready", a_s_tready, 0);
    check("rst_mdata", a_m_tdata, 0);
    check("rst_cnt", a_pkt_cnt, 0);
    check("rst_b_grant", b_grant, 0);

    // Round-robin fairness: 4 sources, 3-beat packets, 4 cycles per packet.
    en = 4'b1111;
    @(negedge pcie_clk);
    sys_rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step();
      check("rr_grant", a_grant, 64'(1) << (k % 4));
      check("rr_data0", a_m_tdata, 64'((k % 4) * 16));
      check("rr_user", a_m_tuser, 64'(k % 4));
      step();
      step();
      check("rr_last", a_m_tlast, 1);
      check("rr_keep", a_m_tkeep, 8'h0F);
      check("rr_data2", a_m_tdata, 64'((k % 4) * 16 + 2));
      step();
      check("rr_idle", a_busy, 0);
    end
    en = '0;
    step();
    check("rr_cnt", a_pkt_cnt, 16'h5555);

    // Strict priority on instance B: ch1 starves while ch0 keeps requesting.
    b_s_tvalid = 2'b11;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      step();
      check("sp_grant0", b_grant, 2'b01);
      check("sp_data0", b_m_tdata, 64'hB0);
      step();
      check("sp_idle", b_grant, 2'b00);
    end
    b_s_tvalid = 2'b10;
    step();
    check("sp_grant1", b_grant, 2'b10);
    check("sp_data1", b_m_tdata, 64'hB1);
    step();
    b_s_tvalid = 2'b00;
    step();
    check("sp_cnt", b_pkt_cnt, 64'h0000_0001_0000_0005);

    // Atomicity: ch1 owns a 4-beat packet through ready and valid gaps
    // while ch0 requests.
    do_reset();
    log_q.delete();
    len[1] = 4;
    len[0] = 2;
    en     = 4'b0010;
    step();
    check("at_grant", a_grant, 4'b0010);
    en = 4'b0011;
    rp = 8'b0110_1010;
    hp = 8'b0010_0110;
    for (int c = 0; c < 8; c++) begin
      a_m_tready = rp[c];
      hold[1]    = hp[c];
      #1;
      check("at_hold_grant", a_grant, 4'b0010);
      check("at_mvalid", a_m_tvalid, !hp[c]);
      check("at_sready", a_s_tready, rp[c] ? 4'b0010 : 4'b0000);
      step();
    end
    a_m_tready = 1'b1;
    hold       = '0;
    n = 0;
    while (a_pkt_cnt[3:0] != 4'd1 && n < 50) begin
      step();
      n++;
    end
    en = '0;
    check("at_timeout", n < 50, 1);
    step();
    step();
    exp6 = '{9'h010, 9'h011, 9'h012, 9'h113, 9'h000, 9'h101};
    check("at_loglen", log_q.size(), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < log_q.size()) check("at_beat", log_q[i], exp6[i]);
    end
    check("at_cnt", a_pkt_cnt, 16'h0011);

    // Single-beat packets on ch0. The 4-bit counter wraps after 16.
    do_reset();
    len[0] = 1;
    en     = 4'b0001;
    for (int k = 0; k < 17; k++) begin
      step();
      check("sb_last", a_m_tlast, 1);
      check("sb_valid", a_m_tvalid, 1);
      step();
      if (k == 15) check("sb_wrap", a_pkt_cnt[3:0], 0);
    end
    en = '0;
    step();
    check("sb_cnt", a_pkt_cnt, 16'h0001);
    check("sb_busy", a_busy, 0);

    // Reset asserted mid-packet: outputs clear without waiting for a clock
    // edge, and a fresh packet then passes intact.
    do_reset();
    len[1] = 5;
    en     = 4'b0010;
    step();
    check("mr_grant", a_grant, 4'b0010);
    step();
    step();
    #3;
    sys_rst_n = 1'b0;
    #1;
    check("mr_mvalid", a_m_tvalid, 0);
    check("mr_grant0", a_grant, 0);
    check("mr_sready", a_s_tready, 0);
    check("mr_mdata", a_m_tdata, 0);
    check("mr_busy", a_busy, 0);
    repeat (2) step();
    log_q.delete();
    @(negedge pcie_clk);
    sys_rst_n = 1'b1;
    step();
    check("mr_regrant", a_grant, 4'b0010);
    n = 0;
    while (a_pkt_cnt[7:4] != 4'd1 && n < 50) begin
      step();
      n++;
    end
    en = '0;
    check("mr_timeout", n < 50, 1);
    step();
    check("mr_loglen", log_q.size(), 5);
    for (int i = 0; i < 5; i++) begin
      if (i < log_q.size()) check("mr_beat", log_q[i], (i == 4) ? 9'h114 : 9'(16 + i));
    end
    check("mr_cnt", a_pkt_cnt, 16'h0010);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tlp_tx_arbiter.md
Name: tlp_tx_arbiter

Overview:
- N-channel, packet-atomic arbiter merging TLP AXI-Stream sources onto the single PCIe core TX stream, all in the pcie_clk domain.
- Typical sources: PIO completion engine (ch0), Ethernet-to-PCIe inject path (ch1), and further injectors.
- Generalises the fixed two-source TX merge to NUM_CH channels with selectable strict-priority or round-robin mode.
- Adds per-channel packet counters for debug register readback.

Parameters:
- C_DATA_WIDTH, 64: TLP stream data width (64 or 128).
- KEEP_WIDTH, C_DATA_WIDTH/8: tkeep width.
- TUSER_WIDTH, 4: tuser width, passed through unchanged.
- NUM_CH, 2: number of source channels, 2..8.
- RR_MODE, 1: 1 = round-robin; 0 = strict priority, lowest index wins.
- CNT_WIDTH, 32: width of each packet counter.

Ports:
- pcie_clk, input, 1: the only clock.
- sys_rst_n, input, 1: asynchronous, active-low reset.
- s_tvalid, input, NUM_CH: per-channel valid.
- s_tready, output, NUM_CH: per-channel ready.
- s_tlast, input, NUM_CH: per-channel last beat.
- s_tdata, input, NUM_CH*C_DATA_WIDTH: packed data, ch i at bits [i*C_DATA_WIDTH +: C_DATA_WIDTH].
- s_tkeep, input, NUM_CH*KEEP_WIDTH: packed keep.
- s_tuser, input, NUM_CH*TUSER_WIDTH: packed user.
- m_tvalid, output, 1: to PCIe core.
- m_tready, input, 1: from PCIe core.
- m_tlast, output, 1: last beat to core.
- m_tdata, output, C_DATA_WIDTH: data to core.
- m_tkeep, output, KEEP_WIDTH: keep to core.
- m_tuser, output, TUSER_WIDTH: user to core.
- grant, output, NUM_CH: one-hot grant of the current owner; all zero when idle.
- busy, output, 1: high when state is XFER.
- pkt_cnt, output, NUM_CH*CNT_WIDTH: completed packets per channel.

Behaviour:
- Reset (sys_rst_n low, asynchronous assert):
  - State goes to IDLE.
  - grant = 0, busy = 0, s_tready = 0, m_tvalid = 0.
  - m_tdata, m_tkeep, m_tuser and m_tlast are 0.
  - All pkt_cnt = 0; round-robin pointer = 0.
  - Release takes effect on the first pcie_clk edge after deassertion.
- State IDLE:
  - If any s_tvalid is high, select a winner and register it into grant.
  - Go to XFER on the same edge; no beat moves in the selection cycle.
  - Arbitration cost: 1 idle cycle per packet.
- Winner selection:
  - RR_MODE=0: lowest-index requesting channel.
  - RR_MODE=1: first requesting channel at or after ptr, searching upward modulo NUM_CH.
- State XFER (combinational mux from the granted channel):
  - m_* = s_*[g] and s_tready[g] = m_tready.
  - s_tready of all other channels = 0.
  - Zero added latency on the data path.
- Beat transfer occurs when m_tvalid && m_tready. A transfer with m_tlast = 1 ends the packet:
  - pkt_cnt[g] increments.
  - In RR mode, ptr = (g+1) mod NUM_CH.
  - grant clears and state returns to IDLE.
- A granted channel dropping s_tvalid mid-packet is legal: the arbiter stays locked (m_tvalid = 0) until that channel's tlast. No preemption, no timeout.
- Single-beat packets: tlast on the first beat → IDLE after 1 transfer.
- Simultaneous new requests arriving during XFER are ignored until IDLE.
- Counter wrap: pkt_cnt wraps from all-ones to 0 silently.
- Reset asserted mid-packet:
  - The packet is abandoned and outputs go to reset values immediately.
  - The downstream core is reset by the same source, so no recovery is required.
- Outside XFER: m_tvalid = 0 and m_tdata etc. = 0, so there is no X propagation.

Decomposition:
- Package tlp_tx_pkg: arb_state_t enum {ARB_IDLE, ARB_XFER}.
- Sub-module rr_pick: combinational one-hot picker.
  - Inputs: req[NUM_CH], ptr, rr_mode.
  - Output: one-hot winner.
  - Instantiated once; testable standalone.

Test Plan:
- Reset/idle: hold sys_rst_n low 10 cycles with s_tvalid=2'b11 → grant=0, m_tvalid=0, s_tready=0, pkt_cnt all 0. Release → grant=2'b01 (RR_MODE=1) one cycle later.
- Round-robin fairness: NUM_CH=4, all channels continuously send 3-beat packets, m_tready=1 → grant sequence 0,1,2,3,0…; each pkt_cnt=5 after 20 packets; 4 cycles per packet.
- Strict priority: RR_MODE=0, ch0 and ch1 both send back-to-back packets → ch1 never granted while ch0 valid. Stop ch0 → ch1 granted next idle cycle.
- Packet atomicity under stall: ch1 granted, 4-beat packet with random m_tready and s_tvalid gaps while ch0 requests → all 4 beats out contiguous and uninterleaved with ch0; ch0 granted only after ch1 tlast.
- Single-beat and wrap: CNT_WIDTH=4, 17 one-beat packets on ch0 → pkt_cnt[0]=1; m_tlast seen each packet.
- Mid-packet reset: assert sys_rst_n low after beat 2 of 5 → outputs zero immediately (asynchronous). After release, a fresh packet on ch1 is granted and transferred intact.
